// File: rtl/fir_coef_sequencer.sv
// fir_coef_sequencer: run-time coefficient controller for the fir tap chain.
//   Collects TAPS serial 32-bit words into a shadow bank and range-checks
//   each one against CWIDTH. A clean load is swapped onto the packed coefs bus
//   in one cycle. settled is then held low until the filter pipeline has
//   flushed every sample that was computed with mixed coefficient sets.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   cfg_start        begin a load (sampled only in IDLE)
//   cfg_data/valid   coefficient word stream; cfg_ready = accept
//   cfg_abort        abandon the current load
//   coefs            active bank; tap k at [(TAPS-1-k)*32 +: 32]
//   busy             high in LOAD and SWAP
//   settled          filter output consistent with active coefs
//   coef_update      one-cycle pulse in the SWAP cycle
//   load_err         one-cycle pulse after a load is discarded
module fir_coef_sequencer #(
  parameter int TAPS    = 27,
  parameter int CWIDTH  = 16,
  parameter int LATENCY = TAPS + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic [31:0]          cfg_data,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic                 cfg_abort,
  output logic [TAPS*32-1:0]   coefs,
  output logic                 busy,
  output logic                 settled,
  output logic                 coef_update,
  output logic                 load_err
);
  localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int SW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {SETTLE, IDLE, LOAD, SWAP} state_t;

  state_t          r_state, w_next;
  logic [IW-1:0]   r_wcnt;
  logic [SW-1:0]   r_scnt;
  logic            r_bad;
  logic            r_load_err;
  logic [31:0]     r_shadow [TAPS];
  logic [31:0]     r_active [TAPS];

  // Word is in range when everything from bit CWIDTH-1 upward is a copy of
  // the sign bit.
  logic [32-CWIDTH:0] w_hi;
  logic               w_in_range, w_last, w_hs, w_good, w_discard;

  assign w_hi       = cfg_data[31:CWIDTH-1];
  assign w_in_range = (&w_hi) | ~(|w_hi);
  assign w_last     = (r_wcnt == IW'(TAPS - 1));
  assign w_hs       = (r_state == LOAD) & cfg_valid & ~cfg_abort;
  assign w_good     = ~r_bad & w_in_range;
  // Abort wins over a simultaneous handshake.
  assign w_discard  = (r_state == LOAD) &
                      (cfg_abort | (w_hs & w_last & ~w_good));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= SETTLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      SETTLE: if (r_scnt <= SW'(1)) w_next = IDLE;
      IDLE:   if (cfg_start) w_next = LOAD;
      LOAD: begin
        if (cfg_abort)            w_next = IDLE;
        else if (w_hs && w_last)  w_next = w_good ? SWAP : IDLE;
      end
      SWAP:   w_next = SETTLE;
      default: w_next = SETTLE;
    endcase
  end

  // Outputs
  always_comb begin
    cfg_ready   = (r_state == LOAD);
    busy        = (r_state == LOAD) | (r_state == SWAP);
    settled     = (r_state == IDLE) | (r_state == LOAD);
    coef_update = (r_state == SWAP);
    load_err    = r_load_err;
  end

  // Datapath: counters, sticky range flag, shadow and active banks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt     <= '0;
      r_scnt     <= SW'(LATENCY);
      r_bad      <= 1'b0;
      r_load_err <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
    end else begin
      r_load_err <= w_discard;
      case (r_state)
        SETTLE: r_scnt <= r_scnt - 1'b1;
        IDLE: begin
          if (cfg_start) begin
            r_wcnt <= '0;
            r_bad  <= 1'b0;
          end
        end
        LOAD: begin
          if (w_hs) begin
            r_shadow[r_wcnt] <= cfg_data;
            r_wcnt           <= r_wcnt + 1'b1;
            if (!w_in_range) r_bad <= 1'b1;
          end
        end
        SWAP: begin
          for (int k = 0; k < TAPS; k++) r_active[k] <= r_shadow[k];
          r_scnt <= SW'(LATENCY);
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_pack
    assign coefs[(TAPS-1-k)*32 +: 32] = r_active[k];
  end

endmodule

// File: tb/tb_fir_coef_sequencer.sv
module tb_fir_coef_sequencer;
  localparam int TAPS = 4;
  localparam int CW   = 16;
  localparam int LAT  = 6;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cfg_start, cfg_valid, cfg_abort, cfg_ready;
  logic [31:0]          cfg_data;
  logic [TAPS*32-1:0]   coefs;
  logic                 busy, settled, coef_update, load_err;

  fir_coef_sequencer #(.TAPS(TAPS), .CWIDTH(CW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_abort(cfg_abort),
    .coefs(coefs), .busy(busy), .settled(settled),
    .coef_update(coef_update), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Word lists are written tap3..tap0 (tap0 in the low 32 bits);
  // expected coefs are written tap0..tap3 (tap0 in the MSB slot).
  localparam logic [127:0] W1 = {32'hFFFFFDF8, 32'h0000023F, 32'h00000271, 32'hFFFFFE02};
  localparam logic [127:0] E1 = {32'hFFFFFE02, 32'h00000271, 32'h0000023F, 32'hFFFFFDF8};
  localparam logic [127:0] W2 = {32'hFFFFFE02, 32'h00000271, 32'h0000023F, 32'hFFFFFDF8};
  localparam logic [127:0] E2 = {32'hFFFFFDF8, 32'h0000023F, 32'h00000271, 32'hFFFFFE02};
  localparam logic [127:0] W3 = {32'h00000002, 32'h00000001, 32'hFFFF8000, 32'h00007FFF};
  localparam logic [127:0] E3 = {32'h00007FFF, 32'hFFFF8000, 32'h00000001, 32'h00000002};
  localparam logic [127:0] WBM = {32'h00000003, 32'h00010000, 32'h00000002, 32'h00000001};
  localparam logic [127:0] WBL = {32'h00008000, 32'h00000003, 32'h00000002, 32'h00000001};

  typedef struct packed { logic upd; logic [127:0] c; } ev_t;
  ev_t          sb[$];
  logic [127:0] cur;
  int           checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every coef_update / load_err pulse must match the next expected
  // event; after an update the new coefs are checked one cycle later.
  initial begin : monitor
    ev_t          e;
    logic         pend;
    logic [127:0] pexp;
    pend = 1'b0;
    pexp = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("coefs_after_swap", coefs, pexp);
          pend = 1'b0;
        end
        if (coef_update || load_err) begin
          if (sb.size() == 0) begin
            chk("unexpected_pulse", {126'd0, coef_update, load_err}, '0);
          end else begin
            e = sb.pop_front();
            chk("event_kind", {126'd0, coef_update, load_err}, {126'd0, e.upd, ~e.upd});
            if (e.upd) begin
              pend = 1'b1;
              pexp = e.c;
            end else begin
              chk("coefs_kept_on_err", coefs, e.c);
            end
          end
        end
      end
    end
  end

  // Count settled-low cycles from now; bounded so a stuck DUT still ends.
  task automatic wait_settle(input int exp_low, input string nm);
    int n;
    bit done;
    n = 0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (settled) done = 1;
      else begin
        n++;
        chk("ready_low_while_unsettled", {127'd0, cfg_ready}, '0);
      end
    end
    chk(nm, n, exp_low);
  endtask

  task automatic load(input logic [3:0][31:0] w, input bit gap, input int abort_at,
                      input bit good, input logic [127:0] exp);
    sb.push_back(good ? ev_t'{1'b1, exp} : ev_t'{1'b0, cur});
    @(posedge clk); #1 cfg_start = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
    for (int k = 0; k < TAPS; k++) begin
      if (gap) begin
        cfg_valid = 1'b0;
        @(posedge clk); #1;
      end
      cfg_valid = 1'b1;
      cfg_data  = w[k];
      cfg_abort = (k == abort_at);
      @(negedge clk);
      chk("ready_in_load", {127'd0, cfg_ready}, 128'd1);
      chk("settled_in_load", {127'd0, settled}, 128'd1);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      cfg_abort = 1'b0;
      if (k == abort_at) break;
    end
    if (good) cur = exp;
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b1; cfg_abort = 1'b0;
    cfg_data = 32'h1234_5678; cur = '0;
    @(negedge clk);
    chk("rst_coefs", coefs, '0);
    chk("rst_flags", {124'd0, settled, cfg_ready, busy, coef_update | load_err}, '0);
    @(posedge clk); #1 rst = 1'b0;
    wait_settle(LAT, "settle_after_reset");
    cfg_valid = 1'b0;

    // Back-to-back load, then LATENCY+1 low cycles starting at SWAP
    load(W1, 1'b0, 99, 1'b1, E1);
    @(negedge clk);
    chk("swap_flags", {124'd0, coef_update, busy, settled, cfg_ready}, {124'd0, 4'b1100});
    wait_settle(LAT, "settle_after_swap1");
    chk("coefs_E1", coefs, E1);

    // Gapped valid, different tap order
    load(W2, 1'b1, 99, 1'b1, E2);
    wait_settle(LAT + 1, "settle_after_swap2");
    chk("coefs_E2", coefs, E2);

    // Out-of-range third word: error, no swap, stays settled
    load(WBM, 1'b0, 99, 1'b0, '0);
    @(negedge clk);
    chk("settled_after_bad_mid", {127'd0, settled}, 128'd1);
    chk("coefs_after_bad_mid", coefs, E2);

    // Range boundaries 0x7FFF and 0xFFFF8000 accepted
    load(W3, 1'b0, 99, 1'b1, E3);
    wait_settle(LAT + 1, "settle_after_swap3");

    // 0x00008000 as last word is rejected
    load(WBL, 1'b0, 99, 1'b0, '0);
    @(negedge clk);
    chk("coefs_after_bad_last", coefs, E3);

    // Abort with valid on word 2
    load(W2, 1'b0, 2, 1'b0, '0);
    @(negedge clk);
    chk("idle_after_abort", {125'd0, cfg_ready, busy, settled}, {125'd0, 3'b001});
    load(W1, 1'b0, 99, 1'b1, E1);
    wait_settle(LAT + 1, "settle_after_abort_reload");
    chk("coefs_after_reload", coefs, E1);

    // Reset in the middle of a settle
    load(W2, 1'b0, 99, 1'b1, E2);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("async_rst_coefs", coefs, '0);
    chk("async_rst_settled", {127'd0, settled}, '0);
    cur = '0;
    @(posedge clk); #1 rst = 1'b0;
    wait_settle(LAT, "settle_after_midrst");
    chk("coefs_after_midrst", coefs, '0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/fir_coef_sequencer.md
Name: fir_coef_sequencer

Overview:
- Run-time coefficient controller for the `fir` tap-chain filter.
- Accepts a serial stream of 32-bit coefficient words into a shadow bank and range-checks each word against CWIDTH.
- Atomically swaps the shadow bank onto the filter's packed `coefs` bus.
- Then holds `settled` low until the filter pipeline has flushed samples computed with mixed coefficient sets.

Parameters:
- TAPS, 27, number of filter taps; must match the attached filter.
- CWIDTH, 16, coefficient width used by the filter; must be 2..32.
- LATENCY, TAPS+2, cycles from coefficient change until the filter output reflects only the new set (TAPS delay registers + multiply register + result register).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_start  in  1  begin a load; sampled only in IDLE.
- cfg_data  in  32  coefficient word, two's complement.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  word accepted when cfg_valid & cfg_ready.
- cfg_abort  in  1  abandon the current load.
- coefs  out  TAPS*32  active coefficient bus; connects directly to the filter `coefs` input.
- busy  out  1  high in LOAD and SWAP.
- settled  out  1  filter output is consistent with the active coefficients.
- coef_update  out  1  one-cycle pulse in the cycle the active bank changes.
- load_err  out  1  one-cycle pulse when a load is discarded.

Behaviour:
- Reset (async, rst=1):
  - Active bank, shadow bank and word counter are all 0.
  - Outputs: cfg_ready=0, busy=0, coef_update=0, load_err=0, settled=0.
  - Settle counter loads LATENCY; state = SETTLE.
- Packing:
  - The k-th accepted word (k = 0..TAPS-1) is tap k.
  - Tap k drives coefs[(TAPS-1-k)*32 +: 32]. The first word therefore lands in the MSB slot.
  - The full 32 bits are stored.
- Range check:
  - A word is in range iff bits [31:CWIDTH-1] are all equal (i.e. it is a sign extension of its low CWIDTH bits).
  - Any out-of-range word sets a sticky `bad` flag, which is cleared on entry to LOAD.
- FSM states: SETTLE, IDLE, LOAD, SWAP.
- SETTLE:
  - Counter decrements each cycle.
  - When it reaches 1, go to IDLE next cycle; settled rises on IDLE entry.
  - cfg_start, cfg_valid and cfg_abort are ignored; cfg_ready=0.
- IDLE:
  - settled=1.
  - cfg_start=1 → LOAD; word counter=0; bad=0.
- LOAD:
  - cfg_ready=1 and busy=1; settled stays 1 because the active bank is untouched.
  - Each handshake writes shadow[counter] and increments the counter; no gaps are required.
  - Accepting word TAPS-1:
    - bad=0 and the last word in range → SWAP.
    - Otherwise → IDLE with a load_err pulse; shadow contents are don't-care.
  - cfg_abort=1 (priority over a simultaneous handshake; that word is not stored) → IDLE, load_err pulse, active bank unchanged.
  - cfg_start in LOAD is ignored.
- SWAP (exactly one cycle):
  - Active bank <= shadow bank; coef_update=1; cfg_ready=0; busy=1.
  - settled falls in this cycle.
  - Next state is SETTLE with the counter loaded to LATENCY.
- Settle timing: settled returns high exactly LATENCY+1 cycles after the SWAP cycle. This count includes the SWAP cycle and the LATENCY SETTLE cycles.
- rst asserted mid-load or mid-settle: all state is lost, and both banks return to zero.
- coefs is registered and changes only in SWAP or on reset; it is glitch-free to the filter.

Test Plan:
- Reset release, TAPS=4, LATENCY=6:
  - Required: coefs=0, settled=0 for 6 cycles then 1.
  - Required: cfg_ready=0 throughout, even with cfg_valid=1.
- Load {-510, 625, 575, -520}, back-to-back valid:
  - Required: cfg_ready high 4 cycles, then a 1-cycle coef_update.
  - Required: coefs = {32'hFFFFFE02, 32'h00000271, 32'h0000023F, 32'hFFFFFDF8} (MSB→LSB).
  - Required: settled low 7 cycles starting at the SWAP cycle.
- Load with cfg_valid toggling every other cycle:
  - Required: exactly 4 words captured in order; the same final coefs as a gap-free load.
- Third word 32'h00010000 with CWIDTH=16:
  - Required: load_err pulse after the 4th word; coefs unchanged; no coef_update; settled stays 1.
- cfg_abort asserted with cfg_valid on word 2:
  - Required: word 2 dropped; IDLE next cycle; load_err=1 for 1 cycle.
  - Required: a subsequent full load succeeds starting from tap 0.
- rst pulsed during SETTLE after a successful swap:
  - Required: coefs=0 immediately (async) and settled=0.
  - Required: a fresh 6-cycle settle follows release.
